// File: rtl/mmio_fifo_ctrl.sv
// mmio_fifo_ctrl: MMIO front end for a shift-register FIFO (push/pop/status/control)
//
// Turns host MMIO writes to DATA_ADDR into FIFO pushes and MMIO reads of
// DATA_ADDR into pops of the head stage. It keeps a shadow valid vector that
// mirrors which stage of the external FIFO holds live data. A two-state FSM
// (IDLE/ADVANCE) shifts bubbles through the FIFO until the oldest entry sits
// on the last stage, where it drives i_fifo_q.
//
// Optional feature: define MMIO_FIFO_CTRL_AUTOADV_EN to enter ADVANCE
// automatically after pops and pushes, so the head is always kept at q.
// Without it, ADVANCE is entered only by a CTRL write with bit0 set.
//
// Ports:
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   i_wr_valid   MMIO write strobe
//   i_wr_addr    MMIO write address
//   i_wr_data    MMIO write data
//   i_rd_valid   MMIO read strobe
//   i_rd_addr    MMIO read address
//   i_rd_tid     MMIO read transaction id
//   o_fifo_en    FIFO shift enable
//   o_fifo_d     FIFO input data (zero when not shifting)
//   i_fifo_q     FIFO last-stage output
//   o_rsp_valid  read response valid, one cycle after the read strobe
//   o_rsp_tid    echoed read transaction id
//   o_rsp_data   read response data
//   o_count      number of live entries
//   o_busy       FSM is in ADVANCE

module mmio_fifo_ctrl #(
   parameter int          DEPTH     = 8,
   parameter int          DATA_W    = 64,
   parameter logic [15:0] DATA_ADDR = 16'h0020,
   parameter logic [15:0] STAT_ADDR = 16'h0022,
   parameter logic [15:0] CTRL_ADDR = 16'h0024,
   localparam int         CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_wr_valid,
   input  logic [15:0]       i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_rd_valid,
   input  logic [15:0]       i_rd_addr,
   input  logic [8:0]        i_rd_tid,
   output logic              o_fifo_en,
   output logic [DATA_W-1:0] o_fifo_d,
   input  logic [DATA_W-1:0] i_fifo_q,
   output logic              o_rsp_valid,
   output logic [8:0]        o_rsp_tid,
   output logic [DATA_W-1:0] o_rsp_data,
   output logic [CNT_W-1:0]  o_count,
   output logic              o_busy
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ADV  = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [DEPTH-1:0]   r_v;
   logic               r_ovf;
   logic               r_unf;
   logic               r_rsp_valid;
   logic [8:0]         r_rsp_tid;
   logic [DATA_W-1:0]  r_rsp_data;

   logic               w_head;
   logic               w_push_req;
   logic               w_pop_req;
   logic               w_ctrl_wr;
   logic               w_pop_ok;
   logic               w_push_ok;
   logic               w_adv_shift;
   logic               w_adv_done;
   logic               w_auto;
   logic               w_shift;
   logic [DEPTH-1:0]   w_v_pop;
   logic [DEPTH-1:0]   w_v_nxt;
   logic [CNT_W-1:0]   w_count;
   logic [DATA_W-1:0]  w_stat;
   logic [DATA_W-1:0]  w_rd_data;

   // ------------------------------------------------------------------
   // Request decode
   // ------------------------------------------------------------------
   assign w_head     = r_v[DEPTH-1];
   assign w_push_req = i_wr_valid && (i_wr_addr == DATA_ADDR);
   assign w_ctrl_wr  = i_wr_valid && (i_wr_addr == CTRL_ADDR);
   assign w_pop_req  = i_rd_valid && (i_rd_addr == DATA_ADDR);
   assign w_pop_ok   = w_pop_req && w_head;

   // A full FIFO can still take a push when the head is popped in the same
   // cycle: the shift discards the popped stage.
   assign w_push_ok  = w_push_req && (r_state == S_IDLE) && (!w_head || w_pop_ok);

   // ADVANCE shifts a bubble in until the oldest entry reaches the last
   // stage; an empty FIFO has nothing to advance.
   assign w_adv_shift = (r_state == S_ADV) && !w_head && (r_v != '0);
   assign w_adv_done  = (r_state == S_ADV) && !w_adv_shift;
   assign w_shift     = w_push_ok || w_adv_shift;

   // ------------------------------------------------------------------
   // Shadow valid vector next value
   // ------------------------------------------------------------------
   always_comb begin
      w_v_pop          = r_v;
      w_v_pop[DEPTH-1] = w_head && !w_pop_ok;
      w_v_nxt          = w_shift ? {w_v_pop[DEPTH-2:0], w_push_ok} : w_v_pop;
   end

   always_comb begin
      w_count = '0;
      for (int i = 0; i < DEPTH; i++)
         w_count = w_count + CNT_W'(r_v[i]);
   end

`ifdef MMIO_FIFO_CTRL_AUTOADV_EN
   // Re-enter ADVANCE whenever the head slot is left empty with data behind it.
   assign w_auto = (w_pop_ok && (w_v_nxt != '0)) || (w_push_ok && !w_v_nxt[DEPTH-1]);
`else
   assign w_auto = 1'b0;
`endif

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  w_state_nxt = ((w_ctrl_wr && i_wr_data[0]) || w_auto) ? S_ADV : S_IDLE;
         S_ADV:   w_state_nxt = (w_adv_done && !w_auto) ? S_IDLE : S_ADV;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      o_busy    = (r_state == S_ADV);
      o_fifo_en = w_shift;
      o_fifo_d  = w_push_ok ? i_wr_data : '0;
   end

   // ------------------------------------------------------------------
   // Shadow vector and sticky flags
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_v   <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         r_v   <= w_v_nxt;
         // A clear command wins over a flag event in the same cycle.
         r_ovf <= (w_ctrl_wr && i_wr_data[1]) ? 1'b0 : (r_ovf || (w_push_req && !w_push_ok));
         r_unf <= (w_ctrl_wr && i_wr_data[1]) ? 1'b0 : (r_unf || (w_pop_req && !w_head));
      end
   end

   // ------------------------------------------------------------------
   // Read responses
   // ------------------------------------------------------------------
   assign w_stat = DATA_W'({16'(w_count), 13'b0, o_busy, r_unf, r_ovf});

   always_comb begin
      w_rd_data = '0;
      if (i_rd_addr == DATA_ADDR)
         w_rd_data = w_head ? i_fifo_q : '0;
      else if (i_rd_addr == STAT_ADDR)
         w_rd_data = w_stat;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_tid   <= '0;
         r_rsp_data  <= '0;
      end else begin
         r_rsp_valid <= i_rd_valid;
         if (i_rd_valid) begin
            r_rsp_tid  <= i_rd_tid;
            r_rsp_data <= w_rd_data;
         end
      end
   end

   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_tid   = r_rsp_tid;
   assign o_rsp_data  = r_rsp_data;
   assign o_count     = w_count;

endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// tb_mmio_fifo_ctrl: table-driven and sequence checks of mmio_fifo_ctrl with a response scoreboard
module tb_mmio_fifo_ctrl;

   localparam logic [15:0] DA = 16'h0020;
   localparam logic [15:0] SA = 16'h0022;
   localparam logic [15:0] CA = 16'h0024;
   localparam logic [15:0] XA = 16'h0030;

   typedef struct {
      logic        wv;
      logic [15:0] wa;
      logic [63:0] wd;
      logic        rv;
      logic [15:0] ra;
      logic [8:0]  tid;
      logic [63:0] rsp;
      logic        e_en;
      logic [63:0] e_d;
      logic        e_busy;
      logic [3:0]  e_cnt;
   } vec_t;

   typedef struct {
      logic [8:0]  tid;
      logic [63:0] data;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_valid = 1'b0;
   logic [15:0] wr_addr = '0;
   logic [63:0] wr_data = '0;
   logic        rd_valid = 1'b0;
   logic [15:0] rd_addr = '0;
   logic [8:0]  rd_tid = '0;
   logic        fifo_en;
   logic [63:0] fifo_d;
   logic [63:0] fifo_q;
   logic        rsp_valid;
   logic [8:0]  rsp_tid;
   logic [63:0] rsp_data;
   logic [3:0]  count;
   logic        busy;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   exp_t sb[$];
   vec_t tbl[28];
   logic [63:0] sr [8];

   mmio_fifo_ctrl dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .i_rd_valid(rd_valid), .i_rd_addr(rd_addr), .i_rd_tid(rd_tid),
      .o_fifo_en(fifo_en), .o_fifo_d(fifo_d), .i_fifo_q(fifo_q),
      .o_rsp_valid(rsp_valid), .o_rsp_tid(rsp_tid), .o_rsp_data(rsp_data),
      .o_count(count), .o_busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // External 8-stage shift-register FIFO
   always @(posedge clk) begin
      if (fifo_en) begin
         for (int i = 7; i > 0; i--) sr[i] <= sr[i-1];
         sr[0] <= fifo_d;
      end
   end
   assign fifo_q = sr[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: each read is due exactly one cycle after it is issued
   always @(negedge clk) begin
      if (rst_n) begin
         if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_valid", 64'(rsp_valid), 64'd1);
            chk("rsp_tid", 64'(rsp_tid), 64'(e.tid));
            chk("rsp_data", rsp_data, e.data);
         end else begin
            chk("rsp_idle", 64'(rsp_valid), 64'd0);
         end
      end
   end

   function automatic vec_t mk(logic wv, logic [15:0] wa, logic [63:0] wd, logic rv,
                               logic [15:0] ra, logic [8:0] tid, logic [63:0] rsp,
                               logic en, logic [63:0] fd, logic bz, logic [3:0] c);
      vec_t t;
      t.wv = wv; t.wa = wa; t.wd = wd; t.rv = rv; t.ra = ra; t.tid = tid; t.rsp = rsp;
      t.e_en = en; t.e_d = fd; t.e_busy = bz; t.e_cnt = c;
      return t;
   endfunction

   function automatic vec_t v_wr(logic [15:0] a, logic [63:0] d, logic en, logic [63:0] fd,
                                 logic bz, logic [3:0] c);
      return mk(1'b1, a, d, 1'b0, 16'h0, 9'h0, 64'h0, en, fd, bz, c);
   endfunction

   function automatic vec_t v_rd(logic [15:0] a, logic [8:0] tid, logic [63:0] rsp,
                                 logic bz, logic [3:0] c);
      return mk(1'b0, 16'h0, 64'h0, 1'b1, a, tid, rsp, 1'b0, 64'h0, bz, c);
   endfunction

   function automatic vec_t v_idle(logic en, logic bz, logic [3:0] c);
      return mk(1'b0, 16'h0, 64'h0, 1'b0, 16'h0, 9'h0, 64'h0, en, 64'h0, bz, c);
   endfunction

   // Drive one cycle; checks combinational outputs and pre-edge state mid-cycle
   task automatic op(input string tag, input vec_t t);
      wr_valid = t.wv; wr_addr = t.wa; wr_data = t.wd;
      rd_valid = t.rv; rd_addr = t.ra; rd_tid = t.tid;
      if (t.rv) sb.push_back('{tid: t.tid, data: t.rsp, due: cyc + 1});
      @(negedge clk);
      chk({tag, ".fifo_en"}, 64'(fifo_en), 64'(t.e_en));
      chk({tag, ".fifo_d"}, fifo_d, t.e_d);
      chk({tag, ".busy"}, 64'(busy), 64'(t.e_busy));
      chk({tag, ".count"}, 64'(count), 64'(t.e_cnt));
      @(posedge clk); #1;
      wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      rd_valid = 1'b0; rd_addr = '0; rd_tid = '0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      sb.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int nb;
      int ne;
      tbl[0]  = v_rd(SA, 9'd5, 64'h0, 1'b0, 4'd0);
      for (int i = 1; i <= 8; i++)
         tbl[i] = v_wr(DA, 64'(i), 1'b1, 64'(i), 1'b0, 4'(i - 1));
      tbl[9]  = v_wr(DA, 64'd9, 1'b0, 64'h0, 1'b0, 4'd8);
      tbl[10] = v_rd(SA, 9'd6, 64'h0008_0001, 1'b0, 4'd8);
      tbl[11] = v_rd(DA, 9'd7, 64'd1, 1'b0, 4'd8);
      tbl[12] = v_rd(XA, 9'd8, 64'h0, 1'b0, 4'd7);
      tbl[13] = v_wr(XA, 64'hff, 1'b0, 64'h0, 1'b0, 4'd7);
      tbl[14] = v_wr(CA, 64'd1, 1'b0, 64'h0, 1'b0, 4'd7);
      tbl[15] = v_idle(1'b1, 1'b1, 4'd7);
      tbl[16] = v_idle(1'b0, 1'b1, 4'd7);
      tbl[17] = mk(1'b1, DA, 64'h55, 1'b1, DA, 9'd9, 64'd2, 1'b1, 64'h55, 1'b0, 4'd7);
      tbl[18] = v_rd(SA, 9'd10, 64'h0007_0001, 1'b0, 4'd7);
      tbl[19] = v_wr(CA, 64'd2, 1'b0, 64'h0, 1'b0, 4'd7);
      tbl[20] = v_rd(DA, 9'd11, 64'd3, 1'b0, 4'd7);
      tbl[21] = v_rd(DA, 9'd12, 64'd0, 1'b0, 4'd6);
      tbl[22] = v_rd(SA, 9'd13, 64'h0006_0002, 1'b0, 4'd6);
      tbl[23] = v_wr(CA, 64'd3, 1'b0, 64'h0, 1'b0, 4'd6);
      tbl[24] = v_idle(1'b1, 1'b1, 4'd6);
      tbl[25] = v_idle(1'b0, 1'b1, 4'd6);
      tbl[26] = v_rd(SA, 9'd14, 64'h0006_0000, 1'b0, 4'd6);
      tbl[27] = v_rd(DA, 9'd15, 64'd4, 1'b0, 4'd6);

      // Reset values, while held and after release
      #12;
      chk("rst.busy", 64'(busy), 64'd0);
      chk("rst.fifo_en", 64'(fifo_en), 64'd0);
      do_reset();
      @(negedge clk);
      chk("rst.count", 64'(count), 64'd0);
      chk("rst.fifo_d", fifo_d, 64'd0);
      chk("rst.rsp_tid", 64'(rsp_tid), 64'd0);
      chk("rst.rsp_data", rsp_data, 64'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 28; i++) op($sformatf("vec%0d", i), tbl[i]);
      repeat (2) @(posedge clk);

      // Advance of three entries: 5 shifts plus one exit cycle
      do_reset();
      op("advA", v_wr(DA, 64'hA, 1'b1, 64'hA, 1'b0, 4'd0));
      op("advB", v_wr(DA, 64'hB, 1'b1, 64'hB, 1'b0, 4'd1));
      op("advC", v_wr(DA, 64'hC, 1'b1, 64'hC, 1'b0, 4'd2));
      op("advCtl", v_wr(CA, 64'd1, 1'b0, 64'h0, 1'b0, 4'd3));
      nb = 0; ne = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!busy) break;
         nb++;
         if (fifo_en) ne++;
         @(posedge clk); #1;
      end
      chk("adv.busy_cycles", 64'(nb), 64'd6);
      chk("adv.shifts", 64'(ne), 64'd5);
      @(posedge clk); #1;
      op("advPop", v_rd(DA, 9'd20, 64'hA, 1'b0, 4'd3));
      repeat (2) @(posedge clk);

      // Underflow, then flag clear
      do_reset();
      op("unfPop", v_rd(DA, 9'd21, 64'h0, 1'b0, 4'd0));
      op("unfStat", v_rd(SA, 9'd22, 64'h2, 1'b0, 4'd0));
      op("unfClr", v_wr(CA, 64'd2, 1'b0, 64'h0, 1'b0, 4'd0));
      op("unfStat2", v_rd(SA, 9'd23, 64'h0, 1'b0, 4'd0));
      repeat (2) @(posedge clk);

      // Asynchronous reset in the middle of ADVANCE
      do_reset();
      op("arPush", v_wr(DA, 64'h77, 1'b1, 64'h77, 1'b0, 4'd0));
      op("arCtl", v_wr(CA, 64'd1, 1'b0, 64'h0, 1'b0, 4'd1));
      op("arAdv", v_idle(1'b1, 1'b1, 4'd1));
      @(negedge clk);
      chk("ar.busy_pre", 64'(busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar.busy", 64'(busy), 64'd0);
      chk("ar.count", 64'(count), 64'd0);
      chk("ar.fifo_en", 64'(fifo_en), 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      repeat (3) @(posedge clk);
      chk("sb.drain", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mmio_fifo_ctrl.md
# mmio_fifo_ctrl

Controller between the AFU MMIO decode and the 64-bit shift-register FIFO (ports `en`/`d`/`q`). It turns host MMIO writes into FIFO pushes and MMIO reads into FIFO pops, with overflow and underflow protection. A shadow valid vector tracks which shift stage holds live data. A small state machine advances the pipeline so that the oldest entry reaches `q`. Read responses return to the AFU Tx c2 logic with the request TID.

## Interface
- `DEPTH`, 8: stage count of the attached shift-register FIFO; must be at least 2.
- `DATA_W`, 64: data width.
- `DATA_ADDR`, 16'h0020: write pushes, read pops.
- `STAT_ADDR`, 16'h0022: read-only status.
- `CTRL_ADDR`, 16'h0024: write-only command.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `wr_valid`  in  1  MMIO write strobe (rx.c0.mmioWrValid).
- `wr_addr`  in  16  MMIO write address.
- `wr_data`  in  DATA_W  MMIO write data.
- `rd_valid`  in  1  MMIO read strobe.
- `rd_addr`  in  16  MMIO read address.
- `rd_tid`  in  9  read TID.
- `fifo_en`  out  1  FIFO shift enable.
- `fifo_d`  out  DATA_W  FIFO input data.
- `fifo_q`  in  DATA_W  FIFO last-stage output.
- `rsp_valid`  out  1  read response valid.
- `rsp_tid`  out  9  echoed TID.
- `rsp_data`  out  DATA_W  response data.
- `count`  out  $clog2(DEPTH+1)  live entries.
- `busy`  out  1  state is ADVANCE.

## Operation
- Shadow vector `v[DEPTH-1:0]`. Bit i means FIFO stage i holds live data; stage DEPTH-1 drives `fifo_q`. `count` = popcount(v).
- On every shift, `v` is updated in the same edge as the FIFO: `v <= {v[DEPTH-2:0], in_bit}`.
- States: IDLE, ADVANCE.
- Push (IDLE only): write to `DATA_ADDR`.
  - Accepted iff `v[DEPTH-1]==0` or a pop is accepted in the same cycle.
  - Accepted push: `fifo_en=1`, `fifo_d=wr_data`, in_bit=1.
  - Rejected push (head unread, or state ADVANCE): data dropped, sticky `ovf` set.
- Pop: read of `DATA_ADDR`.
  - If `v[DEPTH-1]`: `rsp_data <= fifo_q` (pre-edge value), and `v[DEPTH-1]` is cleared.
  - Else: `rsp_data <= 0`, sticky `unf` set.
- Simultaneous pop and push: pop samples the old head; push is accepted; the shift discards the popped stage.
- Status read: `rsp_data <= {count` zero-extended to 16 bits in [31:16], 13'b0, `busy`, `unf`, `ovf}`.
- Any other read address: `rsp_data <= 0`. Every read produces exactly one response.
- CTRL write:
  - bit0 = advance: IDLE→ADVANCE.
  - bit1 = clear `ovf`/`unf`; this takes priority over a same-cycle set.
  - Writes to other addresses are ignored.
- ADVANCE, each cycle:
  - If `v[DEPTH-1]==1` or `v==0`: go to IDLE with no shift.
  - Else: `fifo_en=1`, `fifo_d=0`, in_bit=0.
- `fifo_en`/`fifo_d` are combinational from registered inputs and state. `fifo_d` = 0 when `fifo_en` = 0.

## Timing
- Reset values: state IDLE, `v`=0, `ovf`=`unf`=0, `rsp_valid`=0, `rsp_tid`=0, `rsp_data`=0. As a result `fifo_en`=0, `fifo_d`=0, `count`=0, `busy`=0.
- Push: FIFO and `v` update at the edge ending the `wr_valid` cycle.
- Read: `rsp_valid` is high exactly one cycle, the cycle after `rd_valid`. `rsp_tid`/`rsp_data` are held until the next response.
- ADVANCE: takes at most DEPTH-1 shift cycles, plus one exit cycle.
- An entry pushed into an otherwise empty FIFO reaches the head after DEPTH shifts.
- Reset mid-ADVANCE: returns to IDLE immediately (asynchronous); the FIFO contents are treated as dead.

## Configuration
- `MMIO_FIFO_CTRL_AUTOADV_EN` defined:
  - An accepted pop that leaves `v!=0` enters ADVANCE on the next cycle.
  - A push that leaves `v[DEPTH-1]==0` also enters ADVANCE.
  - Net effect: the head is kept at `q` automatically.
- Undefined: ADVANCE is entered only via CTRL bit0.

## Test plan
- Reset, then read `STAT_ADDR` TID 5: `rsp_valid` is high one cycle later, with `rsp_tid`=5 and `rsp_data`=0.
- Push 8 values 1..8 (DEPTH=8, no macro), then pop: returns 1; `count` goes 8→7; `fifo_en` pulses once per push.
- With the FIFO full and the head unread, push 9: no `fifo_en`, `ovf`=1, status reads 0x0008_0001.
- Push 3 values (0xA, 0xB, 0xC), write CTRL=1: `busy` is high for 5 shift cycles plus 1 exit cycle. The next pop returns 0xA.
- Pop on an empty FIFO: returns 0, `unf`=1. CTRL=2 clears the flags; status then reads 0.
- Assert `rst_n` low mid-ADVANCE: `busy`, `count`, `fifo_en` go to 0 asynchronously. With the macro defined, a pop of a partially filled FIFO auto-advances.
